// File: rtl/dec2421_display_ctrl.sv
// -----------------------------------------------------------------------------
// dec2421_display_ctrl
// Consumer of a 2421-code decade counter. Registers the incoming 2421 digit and
// carry, converts the digit to BCD, keeps a tens digit advanced on carry rising
// edges (0..99 total), drives a 2-digit multiplexed active-low 7-segment
// display and flags codes that are not valid 2421.
//
// Optional feature: define DEC2421_LZB_EN for leading-zero blanking of the
// tens digit (tens slot dark while tens_bcd == 0).
//
// Parameters
//   SCAN_DIV  clk cycles per digit scan slot (>= 2)
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   code_in   in   [3:0] 2421 digit from upstream counter
//   carry_in  in   upstream carry
//   clr       in   synchronous clear of both digits (scan unaffected)
//   ones_bcd  out  [3:0] BCD of last valid code
//   tens_bcd  out  [3:0] BCD tens digit
//   tens_ovf  out  one-cycle pulse on tens wrap 9->0
//   err       out  registered code is not valid 2421
//   seg       out  [6:0] {g,f,e,d,c,b,a}, active-low
//   an        out  [1:0] digit enables, active-low; an[0]=ones, an[1]=tens
// -----------------------------------------------------------------------------
module dec2421_display_ctrl #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code_in,
    input  logic       carry_in,
    input  logic       clr,
    output logic [3:0] ones_bcd,
    output logic [3:0] tens_bcd,
    output logic       tens_ovf,
    output logic       err,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_E   = 7'b0000110;

    // {valid, bcd} for a 2421 code
    function automatic logic [4:0] decode2421(input logic [3:0] c);
        logic [4:0] r;
        case (c)
            4'b0000: r = {1'b1, 4'd0};
            4'b0001: r = {1'b1, 4'd1};
            4'b0010: r = {1'b1, 4'd2};
            4'b0011: r = {1'b1, 4'd3};
            4'b0100: r = {1'b1, 4'd4};
            4'b1011: r = {1'b1, 4'd5};
            4'b1100: r = {1'b1, 4'd6};
            4'b1101: r = {1'b1, 4'd7};
            4'b1110: r = {1'b1, 4'd8};
            4'b1111: r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // Active-low segment font for a BCD digit
    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    logic [3:0]       code_q;
    logic             carry_q;
    logic             armed_q;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic [4:0]       dec;
    logic             carry_rise;

    // Next-state: digit pipeline, tens counter, scan and display
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        ovf_d  = 1'b0;
        err_d  = err_q;
        cnt_d  = cnt_q + CNT_W'(1);
        sel_d  = sel_q;
        an_d   = 2'b10;
        seg_d  = SEG_OFF;

        dec = decode2421(code_q);
        // armed_q keeps a carry held high across reset release from counting
        carry_rise = carry_in & ~carry_q & armed_q;

        if (dec[4]) begin
            ones_d = dec[3:0];
            err_d  = 1'b0;
        end else begin
            err_d  = 1'b1;
        end

        if (carry_rise) begin
            if (tens_q == 4'd9) begin
                tens_d = 4'd0;
                ovf_d  = 1'b1;
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end

        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            err_d  = 1'b0;
            ovf_d  = 1'b0;
        end

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end

        if (!sel_q) begin
            an_d  = 2'b10;
            seg_d = err_q ? SEG_E : font(ones_q);
        end else begin
            an_d  = 2'b01;
            seg_d = font(tens_q);
`ifdef DEC2421_LZB_EN
            if (tens_q == 4'd0) begin
                an_d  = 2'b11;
                seg_d = SEG_OFF;
            end
`endif
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q  <= 4'd0;
            carry_q <= 1'b0;
            armed_q <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= 2'b11;
        end else begin
            code_q  <= code_in;
            carry_q <= carry_in;
            armed_q <= 1'b1;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign ones_bcd = ones_q;
    assign tens_bcd = tens_q;
    assign tens_ovf = ovf_q;
    assign err      = err_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule
